aer_event_injector: RTL and testbench

AER_EVENT_INJECTOR -- requirements
Module: aer_event_injector

---
 rtl/aer_pkg.sv | 15 +
 rtl/aer_sync_fifo.sv | 58 +++++
 rtl/aer_event_injector.sv | 128 ++++++++++++
 tb/tb_aer_event_injector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared AER event-type codes and the injector handshake FSM state encoding.
package aer_pkg;

   localparam logic [1:0] EVT_NEUR    = 2'b00;
   localparam logic [1:0] EVT_BCAST_0 = 2'b01;
   localparam logic [1:0] EVT_BCAST_1 = 2'b10;
   localparam logic [1:0] EVT_INVALID = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_RELEASE = 2'b10
   } aer_state_e;

endpackage

// File: rtl/aer_sync_fifo.sv
// Single-clock FIFO, combinational head read; pop takes effect on the next edge.
// Full is a register that reflects the post-edge count, so accepts never see a combinational path from pop.
module aer_sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_dat,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_pop_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             r_not_full;
   logic             w_push;
   logic             w_pop;

   assign w_push      = i_push && r_not_full;
   assign w_pop       = i_pop && (r_count != '0);
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   // r_not_full stays low during reset so nothing is accepted until the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_not_full <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count    <= w_count_nxt;
         r_not_full <= (w_count_nxt != CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   assign o_pop_dat = r_mem[r_rd_ptr];
   assign o_full    = !r_not_full;
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;

endmodule

// File: rtl/aer_event_injector.sv
// Buffers typed AER events and replays them in order on a 4-phase REQ/ACK link; REQ rises one edge after the head is buffered.
// EVT_READY drops only when the buffer is full; define AER_ACK_SYNC_EN to pass AEROUT_ACK through a 2-flop synchronizer.
module aer_event_injector
   import aer_pkg::*;
#(
   parameter int AER_WIDTH  = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          EVT_VALID,
   output logic                          EVT_READY,
   input  logic [1:0]                    EVT_TYPE,
   input  logic [AER_WIDTH-3:0]          EVT_IDX,
   output logic                          AEROUT_REQ,
   output logic [AER_WIDTH-1:0]          AEROUT_EVENT,
   output logic [AER_WIDTH-3:0]          AEROUT_IDX,
   input  logic                          AEROUT_ACK,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
   output logic [15:0]                   SENT_CNT,
   output logic                          BUSY
);

   aer_state_e           r_state;
   aer_state_e           w_state_nxt;
   logic                 r_req;
   logic                 w_req_nxt;
   logic [AER_WIDTH-1:0] r_event;
   logic [15:0]          r_sent_cnt;
   logic                 w_pop;
   logic                 w_sent_inc;
   logic                 w_ack_s;
   logic                 w_full;
   logic                 w_empty;
   logic [AER_WIDTH-1:0] w_head;
   logic [AER_WIDTH-1:0] w_push_dat;

   assign w_push_dat = {EVT_TYPE, EVT_IDX};

   aer_sync_fifo #(
      .WIDTH (AER_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (EVT_VALID),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_pop_dat  (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (FIFO_COUNT)
   );

`ifdef AER_ACK_SYNC_EN
   logic r_ack_s1;
   logic r_ack_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
      end else begin
         r_ack_s1 <= AEROUT_ACK;
         r_ack_s2 <= r_ack_s1;
      end
   end

   assign w_ack_s = r_ack_s2;
`else
   assign w_ack_s = AEROUT_ACK;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_pop       = 1'b0;
      w_sent_inc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_req_nxt   = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (w_ack_s) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!w_ack_s) begin
               w_sent_inc  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Event data is loaded only on the IDLE pop, so it holds through REQ and RELEASE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_req      <= 1'b0;
         r_event    <= '0;
         r_sent_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         if (w_pop)      r_event    <= w_head;
         if (w_sent_inc) r_sent_cnt <= r_sent_cnt + 16'd1;
      end
   end

   assign EVT_READY    = !w_full;
   assign AEROUT_REQ   = r_req;
   assign AEROUT_EVENT = r_event;
   assign AEROUT_IDX   = r_event[AER_WIDTH-3:0];
   assign SENT_CNT     = r_sent_cnt;
   assign BUSY         = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_aer_event_injector.sv
// Directed bench for aer_event_injector: vector table of single events plus fill, ordering, reset and stuck-ACK sequences.
module tb_aer_event_injector;
   import aer_pkg::*;

`ifdef AER_ACK_SYNC_EN
   localparam int LAG = 3;
`else
   localparam int LAG = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        EVT_VALID;
   logic        EVT_READY;
   logic [1:0]  EVT_TYPE;
   logic [9:0]  EVT_IDX;
   logic        AEROUT_REQ;
   logic [11:0] AEROUT_EVENT;
   logic [9:0]  AEROUT_IDX;
   logic        AEROUT_ACK;
   logic [4:0]  FIFO_COUNT;
   logic [15:0] SENT_CNT;
   logic        BUSY;

   int checks;
   int errors;
   int exp_sent;

   aer_event_injector #(
      .AER_WIDTH  (12),
      .FIFO_DEPTH (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .EVT_VALID    (EVT_VALID),
      .EVT_READY    (EVT_READY),
      .EVT_TYPE     (EVT_TYPE),
      .EVT_IDX      (EVT_IDX),
      .AEROUT_REQ   (AEROUT_REQ),
      .AEROUT_EVENT (AEROUT_EVENT),
      .AEROUT_IDX   (AEROUT_IDX),
      .AEROUT_ACK   (AEROUT_ACK),
      .FIFO_COUNT   (FIFO_COUNT),
      .SENT_CNT     (SENT_CNT),
      .BUSY         (BUSY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  typ;
      logic [9:0]  idx;
      int          dly;
      logic [11:0] exp_ev;
      logic [9:0]  exp_idx;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out", name);
   endtask

   task automatic push(input logic [1:0] t, input logic [9:0] i);
      EVT_VALID = 1'b1;
      EVT_TYPE  = t;
      EVT_IDX   = i;
      @(negedge clk);
      EVT_VALID = 1'b0;
   endtask

   task automatic handshake(input string tag, input int dly, input logic [11:0] exp_ev);
      int n;
      n = 0;
      while (AEROUT_REQ !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (AEROUT_REQ !== 1'b1) begin
         tmo({tag, "_req_rise"});
         return;
      end
      chk({tag, "_ev"}, AEROUT_EVENT, exp_ev);
      repeat (dly) @(negedge clk);
      AEROUT_ACK = 1'b1;
      n = 0;
      while (AEROUT_REQ === 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req_fall_lag"}, n, LAG);
      chk({tag, "_ev_hold"}, AEROUT_EVENT, exp_ev);
      AEROUT_ACK = 1'b0;
      exp_sent++;
      n = 0;
      while (SENT_CNT !== 16'(exp_sent) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_sent_lag"}, n, LAG);
      chk({tag, "_sent_cnt"}, SENT_CNT, 16'(exp_sent));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #3 rst_n = 1'b0;
      #4;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_sent = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int highs;
      int n;
      checks     = 0;
      errors     = 0;
      exp_sent   = 0;
      rst_n      = 1'b0;
      EVT_VALID  = 1'b0;
      EVT_TYPE   = 2'b00;
      EVT_IDX    = '0;
      AEROUT_ACK = 1'b0;

      vecs[0] = '{EVT_NEUR,    10'h155, 1, 12'h155, 10'h155};
      vecs[1] = '{EVT_INVALID, 10'h3FF, 0, 12'hFFF, 10'h3FF};
      vecs[2] = '{2'b01,       10'h02A, 3, 12'h42A, 10'h02A};
      vecs[3] = '{2'b10,       10'h0F0, 2, 12'h8F0, 10'h0F0};
      vecs[4] = '{EVT_NEUR,    10'h000, 5, 12'h000, 10'h000};

      #12;
      chk("rst_req",   AEROUT_REQ, 0);
      chk("rst_ready", EVT_READY, 0);
      chk("rst_count", FIFO_COUNT, 0);
      chk("rst_sent",  SENT_CNT, 0);
      chk("rst_busy",  BUSY, 0);
      chk("rst_event", AEROUT_EVENT, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("ready_before_first_edge", EVT_READY, 0);
      @(negedge clk);
      chk("ready_after_first_edge", EVT_READY, 1);

      for (int v = 0; v < 5; v++) begin
         push(vecs[v].typ, vecs[v].idx);
         chk($sformatf("vec%0d_req_after_e0", v), AEROUT_REQ, 0);
         chk($sformatf("vec%0d_count_after_e0", v), FIFO_COUNT, 1);
         @(negedge clk);
         chk($sformatf("vec%0d_req_after_e1", v), AEROUT_REQ, 1);
         chk($sformatf("vec%0d_count_after_e1", v), FIFO_COUNT, 0);
         chk($sformatf("vec%0d_idx", v), AEROUT_IDX, vecs[v].exp_idx);
         handshake($sformatf("vec%0d", v), vecs[v].dly, vecs[v].exp_ev);
         chk($sformatf("vec%0d_busy_done", v), BUSY, 0);
      end

      push(EVT_NEUR, 10'h100);
      @(negedge clk);
      chk("fill_blocker_req", AEROUT_REQ, 1);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("fill_ready_%0d", k), EVT_READY, 1);
         EVT_VALID = 1'b1;
         EVT_TYPE  = EVT_NEUR;
         EVT_IDX   = 10'h200 + 10'(k);
         @(negedge clk);
         chk($sformatf("fill_count_%0d", k), FIFO_COUNT, k + 1);
      end
      chk("fill_ready_after_16", EVT_READY, 0);
      EVT_IDX = 10'h3EE;
      repeat (3) @(negedge clk);
      chk("fill_17th_count", FIFO_COUNT, 16);
      chk("fill_17th_ready", EVT_READY, 0);
      EVT_VALID = 1'b0;
      handshake("fill_blocker", 0, 12'h100);
      for (int k = 0; k < 16; k++)
         handshake($sformatf("fill_drain%0d", k), k % 3, 12'h200 + 12'(k));
      repeat (5) @(negedge clk);
      chk("fill_no_17th_req", AEROUT_REQ, 0);
      chk("fill_drained_count", FIFO_COUNT, 0);
      chk("fill_drained_busy", BUSY, 0);
      chk("fill_sent_total", SENT_CNT, 22);

      apply_reset();
      chk("ord_reset_sent", SENT_CNT, 0);
      for (int i = 0; i < 8; i++)
         push(EVT_NEUR, 10'(i + 1));
      for (int i = 0; i < 8; i++)
         handshake($sformatf("ord%0d", i + 1), int'($urandom_range(5, 0)), 12'(i + 1));
      chk("ord_sent_8", SENT_CNT, 8);
      chk("ord_empty", FIFO_COUNT, 0);

      push(EVT_NEUR, 10'h011);
      push(EVT_NEUR, 10'h022);
      chk("midrst_req_high", AEROUT_REQ, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_req", AEROUT_REQ, 0);
      chk("midrst_count", FIFO_COUNT, 0);
      chk("midrst_event", AEROUT_EVENT, 0);
      chk("midrst_ready", EVT_READY, 0);
      chk("midrst_sent", SENT_CNT, 0);
      chk("midrst_busy", BUSY, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      exp_sent = 0;
      highs    = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) chk("midrst_ready_after_edge", EVT_READY, 1);
         if (AEROUT_REQ !== 1'b0) highs++;
      end
      chk("midrst_no_event_after", highs, 0);

      AEROUT_ACK = 1'b1;
      repeat (4) @(negedge clk);
      push(EVT_INVALID, 10'h0AB);
      chk("stuck_req_after_e0", AEROUT_REQ, 0);
      @(negedge clk);
      chk("stuck_req_rise", AEROUT_REQ, 1);
      chk("stuck_event", AEROUT_EVENT, 12'hCAB);
      @(negedge clk);
      chk("stuck_req_pulse", AEROUT_REQ, 0);
      repeat (5) @(negedge clk);
      chk("stuck_wait_sent", SENT_CNT, 0);
      chk("stuck_wait_busy", BUSY, 1);
      chk("stuck_event_hold", AEROUT_EVENT, 12'hCAB);
      AEROUT_ACK = 1'b0;
      n = 0;
      while (SENT_CNT !== 16'd1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("stuck_release_lag", n, LAG);
      chk("stuck_sent", SENT_CNT, 1);
      chk("stuck_busy_done", BUSY, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
